mux5_rr_arbiter: RTL and testbench
==================================

Name: mux5_rr_arbiter

Overview:
- Round-robin arbiter and sequencer for the shared 5:1 single-bit mux channel.
- Five requesters compete for the channel. The block grants one at a time and drives the mux select code 0..4 for the winner.
- It enforces a minimum grant length and a maximum grant length (timeout).
- Sits directly in front of the 5:1 mux; its sel output feeds the mux select input.

Parameters:
- N_REQ, 5, number of requesters; fixed at 5 to match the mux.
- SEL_W, 3, width of the select code.
- HOLD_CYC, 4, minimum cycles a grant is held (legal range 1..TIMEOUT_CYC).
- TIMEOUT_CYC, 16, maximum cycles a grant is held before forced release.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- req  in  5  request per requester; level, held high while the channel is wanted.
- done  in  5  per-requester release strobe; only the owner's bit is honoured.
- sel  out  3  mux select code of the current owner; 0 when idle.
- grant  out  5  one-hot grant; all zero when idle.
- busy  out  1  high while any grant is active.
- timeout  out  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Reset (rst_n low at a clk edge):
  - sel=0, grant=0, busy=0, timeout=0.
  - FSM goes to IDLE, hold counter cnt=0, round-robin pointer ptr=4, so the first winner after reset is requester 0.
  - Reset during an active grant drops the grant in that same edge. No partial state is kept.
- States: IDLE and GNT.
- IDLE:
  - If req is nonzero, the winner is the first set bit searching ptr+1, ptr+2, … modulo 5 (4 wraps to 0).
  - Next edge: grant=onehot(winner), sel=winner, busy=1, cnt=0, ptr=winner, state GNT.
  - Latency from req to grant is 1 cycle.
  - If req is all zero, stay in IDLE with outputs at their idle values.
- GNT:
  - cnt increments each cycle and saturates at TIMEOUT_CYC-1.
  - Release condition: (cnt >= HOLD_CYC-1 AND (done[owner] OR NOT req[owner])) OR cnt == TIMEOUT_CYC-1.
  - Forced release: if cnt == TIMEOUT_CYC-1 and the voluntary condition is false, timeout=1 for exactly that release cycle's next edge.
  - On release, if any req bit other than the owner's is set, re-arbitrate in the same cycle.
    - Search starts at owner+1, so the owner is checked last.
    - Next edge is a back-to-back grant to the new winner with cnt=0. There is no idle bubble.
  - Only the owner still requesting: the owner is re-granted with cnt=0.
  - No requests at all: go to IDLE with sel=0, grant=0, busy=0.
- Boundary rules:
  - The owner drops req before HOLD_CYC: the grant is held and sel is unchanged until the hold is met.
  - done for a non-owner bit is ignored. done and req are not otherwise qualified.
  - A req arriving in the same cycle as a release competes in that same arbitration.
- Output invariants:
  - sel is never 5..7.
  - grant is always zero or one-hot, and sel always equals the index of the set grant bit.
  - busy equals the OR of grant.
- All outputs are registered. There are no combinational input-to-output paths.
- cnt width is clog2(TIMEOUT_CYC).

Decomposition:
- Shared package mux_pkg:
  - N_REQ and SEL_W constants.
  - State enum {IDLE, GNT}.
  - A function that converts a select code to one-hot.
- One sub-module, rr_pick5: combinational round-robin priority search. Inputs are req[4:0] and start[2:0]; outputs are winner[2:0] and found.
- The top level holds the FSM, cnt, ptr and output registers.

Test Plan:
- Single requester: reset, then req=5'b00100 → next edge grant=00100, sel=2, busy=1. Drop req at cycle 1 → grant held through cnt=3, then IDLE with sel=0, busy=0.
- Fairness: req=5'b11111 held, each requester asserts done on its 4th grant cycle → grant sequence 0,1,2,3,4,0; each grant 4 cycles; no idle cycle between grants.
- Timeout: req=5'b00011, requester 0 never drops or dones → grant 0 for 16 cycles, timeout pulse of 1 cycle, next grant to requester 1 with sel=1.
- Non-owner done ignored: owner 3 with req held, done=5'b00001 pulses → grant stays on 3. Only done[3] after cnt>=3 releases.
- Wrap: owner 4 releases while req=5'b10001 → next grant 0 (sel=0, grant=00001), not 4.
- Reset mid-grant: rst_n low during grant to 2 at cnt=5 → next edge all outputs 0. After release with req=5'b00100 → grant 2 after 1 cycle. ptr reset is checked by req=11111 → first grant 0.

Source files
------------

// File: rtl/mux5_rr_arbiter_pkg.sv
// Shared constants, FSM state type and select-code helpers for the 5:1 mux arbiter.
package mux_pkg;

  localparam int N_REQ = 5;
  localparam int SEL_W = 3;

  typedef enum logic {
    IDLE = 1'b0,
    GNT  = 1'b1
  } state_t;

  // Out-of-range codes map to all-zero so a corrupted select never grants two owners.
  function automatic logic [N_REQ-1:0] sel_to_onehot(input logic [SEL_W-1:0] sel);
    logic [N_REQ-1:0] oh;
    case (sel)
      3'd0:    oh = 5'b00001;
      3'd1:    oh = 5'b00010;
      3'd2:    oh = 5'b00100;
      3'd3:    oh = 5'b01000;
      3'd4:    oh = 5'b10000;
      default: oh = 5'b00000;
    endcase
    return oh;
  endfunction

  // Successor in the 0..4 ring; illegal codes restart the ring at 0.
  function automatic logic [SEL_W-1:0] next_idx(input logic [SEL_W-1:0] idx);
    logic [SEL_W-1:0] nxt;
    if (idx >= 3'd4) begin
      nxt = 3'd0;
    end else begin
      nxt = idx + 3'd1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/mux5_rr_arbiter_if.sv
// Request/release and grant/select bundle between the requesters and the arbiter.
interface mux5_rr_arbiter_if;
  import mux_pkg::*;

  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] done;
  logic [SEL_W-1:0] sel;
  logic [N_REQ-1:0] grant;
  logic             busy;
  logic             timeout;

  modport master (
    input  req,
    input  done,
    output sel,
    output grant,
    output busy,
    output timeout
  );

  modport slave (
    output req,
    output done,
    input  sel,
    input  grant,
    input  busy,
    input  timeout
  );

endinterface

// File: rtl/mux5_rr_arbiter_pick.sv
// Combinational round-robin search: first set req bit at start, start+1, ... modulo 5.
module rr_pick5
  import mux_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [SEL_W-1:0] start,
  output logic [SEL_W-1:0] winner,
  output logic             found
);

  logic [SEL_W-1:0] idx_s;

  // Walk the ring once, keeping the first hit.
  always_comb begin
    winner = 3'd0;
    found  = 1'b0;
    if (start > 3'd4) begin
      idx_s = 3'd0;
    end else begin
      idx_s = start;
    end
    for (int i = 0; i < N_REQ; i++) begin
      if (!found && req[idx_s]) begin
        found  = 1'b1;
        winner = idx_s;
      end else begin
        found  = found;
      end
      idx_s = next_idx(idx_s);
    end
  end

endmodule

// File: rtl/mux5_rr_arbiter.sv
// Round-robin arbiter for the shared 5:1 mux: one owner at a time, minimum hold, forced timeout.
module mux5_rr_arbiter
  import mux_pkg::*;
#(
  parameter int HOLD_CYC    = 4,
  parameter int TIMEOUT_CYC = 16
)(
  input  logic               clk,
  input  logic               rst_n,
  mux5_rr_arbiter_if.master  bus
);

  localparam int CNT_W = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] TMO_LAST  = CNT_W'(TIMEOUT_CYC - 1);

  state_t           state_r, state_n;
  logic [CNT_W-1:0] cnt_r, cnt_n;
  logic [SEL_W-1:0] ptr_r, ptr_n;
  logic [SEL_W-1:0] sel_r, sel_n;
  logic [N_REQ-1:0] grant_r, grant_n;
  logic             busy_r, busy_n;
  logic             timeout_r, timeout_n;

  logic [SEL_W-1:0] start_s;
  logic [SEL_W-1:0] winner_s;
  logic             found_s;
  logic             vol_s;
  logic             tmo_s;
  logic             release_s;

  // In GNT ptr equals the owner, so this also makes the owner the last candidate.
  assign start_s = next_idx(ptr_r);

  rr_pick5 u_pick (
    .req    (bus.req),
    .start  (start_s),
    .winner (winner_s),
    .found  (found_s)
  );

  assign vol_s     = (cnt_r >= HOLD_LAST) && (bus.done[sel_r] || !bus.req[sel_r]);
  assign tmo_s     = (cnt_r == TMO_LAST);
  assign release_s = vol_s || tmo_s;

  // Next-state and next-output decode.
  always_comb begin
    state_n   = state_r;
    cnt_n     = cnt_r;
    ptr_n     = ptr_r;
    sel_n     = sel_r;
    grant_n   = grant_r;
    busy_n    = busy_r;
    timeout_n = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s) begin
          state_n = GNT;
          cnt_n   = '0;
          ptr_n   = winner_s;
          sel_n   = winner_s;
          grant_n = sel_to_onehot(winner_s);
          busy_n  = 1'b1;
        end else begin
          sel_n   = 3'd0;
          grant_n = 5'b00000;
          busy_n  = 1'b0;
        end
      end
      GNT: begin
        if (release_s) begin
          timeout_n = tmo_s && !vol_s;
          if (found_s) begin
            cnt_n   = '0;
            ptr_n   = winner_s;
            sel_n   = winner_s;
            grant_n = sel_to_onehot(winner_s);
            busy_n  = 1'b1;
          end else begin
            state_n = IDLE;
            cnt_n   = '0;
            sel_n   = 3'd0;
            grant_n = 5'b00000;
            busy_n  = 1'b0;
          end
        end else if (cnt_r != TMO_LAST) begin
          cnt_n = cnt_r + CNT_W'(1);
        end else begin
          cnt_n = cnt_r;
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
        sel_n   = 3'd0;
        grant_n = 5'b00000;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State, counter, pointer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      cnt_r     <= '0;
      ptr_r     <= 3'd4;
      sel_r     <= 3'd0;
      grant_r   <= 5'b00000;
      busy_r    <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      state_r   <= state_n;
      cnt_r     <= cnt_n;
      ptr_r     <= ptr_n;
      sel_r     <= sel_n;
      grant_r   <= grant_n;
      busy_r    <= busy_n;
      timeout_r <= timeout_n;
    end
  end

  assign bus.sel     = sel_r;
  assign bus.grant   = grant_r;
  assign bus.busy    = busy_r;
  assign bus.timeout = timeout_r;

endmodule

// File: tb/tb_mux5_rr_arbiter.sv
// Directed bench: vector table for single-owner/non-owner-done/wrap, hand sequences for fairness, timeout, reset.
module tb_mux5_rr_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  mux5_rr_arbiter_if bus_if ();

  mux5_rr_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst_n;
    logic [4:0] req;
    logic [4:0] done;
    logic [2:0] sel;
    logic [4:0] grant;
    logic       busy;
    logic       timeout;
  } vec_t;

  vec_t vecs[21];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic [2:0] s, input logic [4:0] g,
                         input logic b, input logic t);
    chk({tag, ".sel"},     {5'd0, bus_if.sel},     {5'd0, s});
    chk({tag, ".grant"},   {3'd0, bus_if.grant},   {3'd0, g});
    chk({tag, ".busy"},    {7'd0, bus_if.busy},    {7'd0, b});
    chk({tag, ".timeout"}, {7'd0, bus_if.timeout}, {7'd0, t});
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    bus_if.req  = 5'b00000;
    bus_if.done = 5'b00000;
    tick();
    rst_n = 1'b1;
  endtask

  initial begin
    logic [4:0] one_v;
    logic [2:0] w;
    clk         = 1'b0;
    rst_n       = 1'b0;
    checks      = 0;
    failures    = 0;
    one_v       = 5'b00001;
    bus_if.req  = 5'b00000;
    bus_if.done = 5'b00000;

    // {rst_n, req, done} applied, then expected {sel, grant, busy, timeout} after the edge
    vecs[0]  = '{1'b0, 5'b00000, 5'b00000, 3'd0, 5'b00000, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 5'b00100, 5'b00000, 3'd2, 5'b00100, 1'b1, 1'b0};
    vecs[2]  = '{1'b1, 5'b00000, 5'b00000, 3'd2, 5'b00100, 1'b1, 1'b0};
    vecs[3]  = '{1'b1, 5'b00000, 5'b00000, 3'd2, 5'b00100, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 5'b00000, 5'b00000, 3'd2, 5'b00100, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 5'b00000, 5'b00000, 3'd0, 5'b00000, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 5'b00000, 5'b00000, 3'd0, 5'b00000, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 5'b01000, 5'b00000, 3'd3, 5'b01000, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 5'b01000, 5'b00001, 3'd3, 5'b01000, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 5'b01000, 5'b00001, 3'd3, 5'b01000, 1'b1, 1'b0};
    vecs[10] = '{1'b1, 5'b01000, 5'b00001, 3'd3, 5'b01000, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 5'b01000, 5'b00001, 3'd3, 5'b01000, 1'b1, 1'b0};
    vecs[12] = '{1'b1, 5'b11001, 5'b01000, 3'd4, 5'b10000, 1'b1, 1'b0};
    vecs[13] = '{1'b1, 5'b10001, 5'b00000, 3'd4, 5'b10000, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 5'b10001, 5'b00000, 3'd4, 5'b10000, 1'b1, 1'b0};
    vecs[15] = '{1'b1, 5'b10001, 5'b00000, 3'd4, 5'b10000, 1'b1, 1'b0};
    vecs[16] = '{1'b1, 5'b10001, 5'b10000, 3'd0, 5'b00001, 1'b1, 1'b0};
    vecs[17] = '{1'b1, 5'b00000, 5'b00000, 3'd0, 5'b00001, 1'b1, 1'b0};
    vecs[18] = '{1'b1, 5'b00000, 5'b00000, 3'd0, 5'b00001, 1'b1, 1'b0};
    vecs[19] = '{1'b1, 5'b00000, 5'b00000, 3'd0, 5'b00001, 1'b1, 1'b0};
    vecs[20] = '{1'b1, 5'b00000, 5'b00000, 3'd0, 5'b00000, 1'b0, 1'b0};

    for (int i = 0; i < 21; i++) begin
      rst_n       = vecs[i].rst_n;
      bus_if.req  = vecs[i].req;
      bus_if.done = vecs[i].done;
      tick();
      chk_out($sformatf("vec%0d", i), vecs[i].sel, vecs[i].grant, vecs[i].busy, vecs[i].timeout);
    end

    // Fairness: all requesting, each owner releases via done on its 4th cycle.
    do_reset();
    bus_if.req = 5'b11111;
    tick();
    for (int g = 0; g < 6; g++) begin
      w = 3'(g % 5);
      for (int c = 0; c < 4; c++) begin
        chk_out($sformatf("fair_g%0d_c%0d", g, c), w, one_v << w, 1'b1, 1'b0);
        bus_if.done = (c == 3) ? (one_v << w) : 5'b00000;
        tick();
      end
    end
    bus_if.done = 5'b00000;

    // Timeout: requester 0 never lets go, requester 1 waits.
    do_reset();
    bus_if.req = 5'b00011;
    tick();
    for (int c = 0; c < 16; c++) begin
      chk_out($sformatf("tmo_c%0d", c), 3'd0, 5'b00001, 1'b1, 1'b0);
      tick();
    end
    chk_out("tmo_release", 3'd1, 5'b00010, 1'b1, 1'b1);
    tick();
    chk_out("tmo_after", 3'd1, 5'b00010, 1'b1, 1'b0);

    // Reset mid-grant drops everything at once; ptr restarts at 4.
    do_reset();
    bus_if.req = 5'b00100;
    tick();
    for (int c = 0; c < 5; c++) tick();
    chk_out("mid_cnt5", 3'd2, 5'b00100, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    chk_out("mid_rst", 3'd0, 5'b00000, 1'b0, 1'b0);
    rst_n = 1'b1;
    tick();
    chk_out("mid_regrant", 3'd2, 5'b00100, 1'b1, 1'b0);
    do_reset();
    bus_if.req = 5'b11111;
    tick();
    chk_out("ptr_reset", 3'd0, 5'b00001, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
